// File: rtl/hd_pkg.sv
// Shared definitions for the Hamming-coded packet interface: widths, the
// transmitter FSM state type and the SEC-DED encode / control-pack helpers.
package hd_pkg;

    localparam int DATA_WIDTH   = 16;
    localparam int PRIORITY_BIT = 3;
    localparam int PORT_BIT     = 4;
    localparam int RAW_BIT      = 11;
    localparam int MAX_WORDS    = 63;
    localparam int LEN_BIT      = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CTRL,
        ST_DATA,
        ST_EOP,
        ST_GAP
    } hd_state_t;

    // Extended Hamming (16,11): data at non-power-of-two positions, check
    // bits at 1/2/4/8, overall parity in bit 0 for double-error detection.
    function automatic logic [DATA_WIDTH-1:0] hd_encode(input logic [RAW_BIT-1:0] d);
        logic [DATA_WIDTH-1:0] c;
        c        = '0;
        c[3]     = d[0];
        c[5]     = d[1];
        c[6]     = d[2];
        c[7]     = d[3];
        c[15:9]  = d[10:4];
        c[1]     = c[3] ^ c[5] ^ c[7] ^ c[9] ^ c[11] ^ c[13] ^ c[15];
        c[2]     = c[3] ^ c[6] ^ c[7] ^ c[10] ^ c[11] ^ c[14] ^ c[15];
        c[4]     = c[5] ^ c[6] ^ c[7] ^ c[12] ^ c[13] ^ c[14] ^ c[15];
        c[8]     = ^c[15:9];
        c[0]     = ^c[15:1];
        return c;
    endfunction

    // Control word payload: upper bits reserved as zero, then priority, port.
    function automatic logic [RAW_BIT-1:0] hd_ctrl_pack(
        input logic [PRIORITY_BIT-1:0] prior,
        input logic [PORT_BIT-1:0]     port
    );
        return {{(RAW_BIT-PRIORITY_BIT-PORT_BIT){1'b0}}, prior, port};
    endfunction

endpackage

// File: rtl/hd_enc16.sv
// Combinational 11-to-16 bit extended Hamming encoder.
module hd_enc16
    import hd_pkg::*;
(
    input  logic [RAW_BIT-1:0]    i_raw,
    output logic [DATA_WIDTH-1:0] o_code
);

    // Pure encode, no state.
    always_comb begin
        o_code = hd_encode(i_raw);
    end

endmodule

// File: rtl/hd_tx.sv
// Packet transmitter: frames a header-described packet as sop / control word /
// encoded payload / eop, followed by a fixed two-cycle idle gap.
module hd_tx
    import hd_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    pkt_start,
    output logic                    start_rdy,
    input  logic [PRIORITY_BIT-1:0] pkt_prior,
    input  logic [PORT_BIT-1:0]     pkt_port,
    input  logic [LEN_BIT-1:0]      pkt_len,
    input  logic                    s_vld,
    output logic                    s_rdy,
    input  logic [RAW_BIT-1:0]      s_data,
    input  logic [DATA_WIDTH-1:0]   inj_mask,
    output logic                    wr_sop,
    output logic                    wr_eop,
    output logic                    wr_vld,
    output logic [DATA_WIDTH-1:0]   wr_data
);

    hd_state_t               r_state;
    logic [PRIORITY_BIT-1:0] r_prior;
    logic [PORT_BIT-1:0]     r_port;
    logic [LEN_BIT-1:0]      r_cnt;
    logic                    r_gap;
    logic                    r_sop;
    logic                    r_eop;
    logic                    r_vld;
    logic [DATA_WIDTH-1:0]   r_data;

    logic [RAW_BIT-1:0]      w_enc_in;
    logic [DATA_WIDTH-1:0]   w_enc_out;
    logic                    w_hs;

    // Handshake flags are decodes of the state register, so they drop the
    // moment the FSM leaves IDLE/DATA and never accept an extra word.
    assign start_rdy = (r_state == ST_IDLE);
    assign s_rdy     = (r_state == ST_DATA);
    assign w_hs      = s_vld && (r_state == ST_DATA);

    // One shared encoder: control word while in CTRL, payload otherwise.
    assign w_enc_in = (r_state == ST_CTRL) ? hd_ctrl_pack(r_prior, r_port) : s_data;

    hd_enc16 u_enc (
        .i_raw  (w_enc_in),
        .o_code (w_enc_out)
    );

    assign wr_sop  = r_sop;
    assign wr_eop  = r_eop;
    assign wr_vld  = r_vld;
    assign wr_data = r_data;

    // Packet FSM with registered framing outputs; wr_data holds across bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_prior <= '0;
            r_port  <= '0;
            r_cnt   <= '0;
            r_gap   <= 1'b0;
            r_sop   <= 1'b0;
            r_eop   <= 1'b0;
            r_vld   <= 1'b0;
            r_data  <= '0;
        end else begin
            r_sop <= 1'b0;
            r_eop <= 1'b0;
            r_vld <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_data <= '0;
                    if (pkt_start) begin
                        r_prior <= pkt_prior;
                        r_port  <= pkt_port;
                        r_cnt   <= pkt_len;
                        r_sop   <= 1'b1;
                        r_vld   <= 1'b1;
                        r_state <= ST_CTRL;
                    end
                end
                ST_CTRL: begin
                    // Injection mask deliberately not applied to the control word.
                    r_vld   <= 1'b1;
                    r_data  <= w_enc_out;
                    r_state <= (r_cnt == '0) ? ST_EOP : ST_DATA;
                end
                ST_DATA: begin
                    if (w_hs) begin
                        r_vld <= 1'b1;
                        r_data <= w_enc_out ^ inj_mask;
                        r_cnt <= r_cnt - 1'b1;
                        if (r_cnt == LEN_BIT'(1)) begin
                            r_state <= ST_EOP;
                        end
                    end
                end
                ST_EOP: begin
                    r_eop   <= 1'b1;
                    r_data  <= '0;
                    r_gap   <= 1'b0;
                    r_state <= ST_GAP;
                end
                ST_GAP: begin
                    r_data <= '0;
                    if (r_gap) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_gap <= 1'b1;
                    end
                end
                default: begin
                    r_data  <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
